signed_round_sat: RTL and testbench
===================================

# signed_round_sat

Pipelined requantiser that sits directly downstream of `signed_adder`. It takes the full-width (bit-grown) signed sum, drops `IWID-OWID` LSBs with rounding, and saturates the result to `OWID` bits. A valid/ready handshake lets it feed back-pressuring consumers such as FIFOs and filter stages. A sticky overflow flag records any saturation event.

## Interface
- `IWID`, 17, input width; matches the adder `OUTWID`. Must satisfy `IWID >= OWID+1`.
- `OWID`, 12, output width.
- Derived: `D = IWID-OWID` (dropped bits, at least 1).

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  upstream data valid.
- `o_ready`  out  1  block can accept `i_data` this cycle.
- `i_data`  in  IWID  signed input sample.
- `o_valid`  out  1  `o_data` valid.
- `i_ready`  in  1  downstream accepts `o_data`.
- `o_data`  out  OWID  signed rounded/saturated sample.
- `o_ovf`  out  1  registered; 1 when the sample now in stage 2 was saturated.
- `i_ovf_clr`  in  1  clears `o_ovf_sticky`.
- `o_ovf_sticky`  out  1  set by any saturation since the last clear or reset.

## Operation
- Transfer in: `i_valid && o_ready`. Transfer out: `o_valid && i_ready`.
- Stage 1 (round) registers `r1`, which is `IWID+1` bits wide.
  - Half-up mode: `r1 = x + 2^(D-1)`.
  - The addition is sign-extended and cannot wrap.
- Stage 2 (saturate) computes `q = r1 >>> D` (arithmetic shift).
  - If `q > 2^(OWID-1)-1`: `o_data = 2^(OWID-1)-1` and `o_ovf = 1`.
  - If `q < -2^(OWID-1)`: `o_data = -2^(OWID-1)` and `o_ovf = 1`.
  - Otherwise `o_data = q[OWID-1:0]` and `o_ovf = 0`.
- `o_ovf_sticky` update:
  - Set in the cycle a saturated sample is loaded into stage 2.
  - Cleared by `i_ovf_clr`.
  - If set and clear happen in the same cycle, set wins.
- Flow control:
  - Stage 2 loads when `!s2_valid || i_ready`.
  - Stage 1 advances into stage 2 under the same condition.
  - `o_ready = !s1_valid || !s2_valid || i_ready`. This is a combinational path from `i_ready`; it is intentional.
- Stalls:
  - While `o_valid && !i_ready`, `o_data`, `o_ovf` and `o_valid` hold stable.
  - A stalled stage 1 holds `r1`.
- Data registers do not change without a corresponding valid load. Bubbles (valid=0) leave data registers unchanged.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_ovf=0`, `o_ovf_sticky=0`, internal valids 0, `r1=0`.
- Therefore `o_ready=1` in the first cycle after reset.
- Latency is 2 cycles from the accept edge to `o_valid` with no stall.
- Throughput is 1 sample/cycle with `i_ready` held high.
- Full condition: both stages valid and `i_ready=0`. Then `o_ready=0` and nothing is lost or duplicated.
- Reset mid-operation flushes both stages: in-flight samples are discarded and `o_valid` is 0 on the next cycle.
- `i_valid` is ignored while `i_reset=1`.

## Configuration
- Macro: `SIGNED_ROUND_SAT_CONVERGENT_EN`.
- Defined: convergent rounding (ties to even). Stage 1 computes `r1 = x + (2^(D-1) - 1) + x[D]`, so an exact half rounds to the even kept value.
- Undefined: round-half-up, `r1 = x + 2^(D-1)`. Ties round toward +infinity.
- Latency, handshake and saturation are identical in both builds.

## Test plan
All cases use `IWID=17`, `OWID=12`, `D=5`.

- **Rounding ties:** feed 16, 48, -16, -48.
  - Half-up expects 1, 2, 0, -1.
  - Convergent expects 0, 2, 0, -2.
  - `o_ovf=0` in every case.
- **Saturation:**
  - 65535 → 2047, `o_ovf=1`, sticky sets.
  - 65519 → 2047, `o_ovf=0`.
  - -65536 → -2048, `o_ovf=0`.
  - 65520 → 2047, `o_ovf=1` in both builds.
- **Back-pressure:** stream 0..31×32 with `i_ready` toggling pseudo-randomly.
  - Output is 0..31 in order, with no loss or duplication.
  - `o_data` is stable during stalls.
  - `o_ready` drops only when both stages are full and `i_ready=0`.
- **Sticky flag:**
  - Saturate once, then send in-range data: sticky stays 1.
  - Pulse `i_ovf_clr`: sticky goes to 0.
  - Assert `i_ovf_clr` in the same cycle as a saturating load: sticky reads 1.
- **Reset mid-stream:** assert `i_reset` for 1 cycle with both stages valid.
  - Next cycle: `o_valid=0`, `o_data=0`, sticky 0, `o_ready=1`.
  - The first post-reset sample appears 2 cycles after it is accepted.
- **Throughput:** with `i_ready=1` and `i_valid=1` continuously for 100 cycles, expect exactly 100 outputs, starting in cycle 2.

Source files
------------

// File: rtl/signed_round_sat.sv
// signed_round_sat
// Two-stage requantiser: rounds away IWID-OWID LSBs of a signed sample, then
// saturates the result to OWID bits, with a valid/ready handshake on both sides.
// Optional build macro SIGNED_ROUND_SAT_CONVERGENT_EN selects convergent
// (ties-to-even) rounding; when undefined, ties round half-up toward +infinity.

module signed_round_sat #(
   parameter int IWID = 17,
   parameter int OWID = 12
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [IWID-1:0] i_data,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [OWID-1:0] o_data,
   output logic            o_ovf,
   input  logic            i_ovf_clr,
   output logic            o_ovf_sticky
);

   localparam int D = IWID - OWID;

   // Rounding constant 2^(D-1), kept at the stage-1 width so the add never wraps
   localparam logic [IWID:0] HALF = (IWID+1)'(1) << (D-1);

   logic            s1_valid;
   logic            s2_valid;
   logic [IWID:0]   r1;
   logic [IWID:0]   x_ext;
   logic [IWID:0]   round_bias;
   logic [OWID:0]   q;
   logic [OWID-1:0] sat_data;
   logic            sat_ovf;
   logic            load2;
   logic            accept;

   // Handshake: stage 2 moves whenever it is empty or being drained, and the
   // input side is ready unless both stages are full and downstream is stalled
   always_comb begin
      load2   = !s2_valid || i_ready;
      o_ready = !s1_valid || !s2_valid || i_ready;
      accept  = i_valid && o_ready;
   end

   // Stage-1 rounding bias: half-up, or half-minus-one plus the kept LSB so an
   // exact tie lands on the even kept value
   always_comb begin
      x_ext = {i_data[IWID-1], i_data};
`ifdef SIGNED_ROUND_SAT_CONVERGENT_EN
      round_bias = HALF - (IWID+1)'(1) + {{IWID{1'b0}}, i_data[D]};
`else
      round_bias = HALF;
`endif
   end

   // Stage-2 saturation: the shifted value is exactly OWID+1 bits, so it fits
   // in OWID bits precisely when its top two bits agree
   always_comb begin
      q        = r1[IWID:D];
      sat_ovf  = q[OWID] != q[OWID-1];
      sat_data = q[OWID-1:0];
      if (sat_ovf) begin
         if (q[OWID]) begin
            sat_data = {1'b1, {(OWID-1){1'b0}}};
         end else begin
            sat_data = {1'b0, {(OWID-1){1'b1}}};
         end
      end
   end

   // Stage 1: capture the rounded sample on accept, empty when it moves on
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_valid <= 1'b0;
         r1       <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         r1       <= x_ext + round_bias;
      end else if (load2) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: load the saturated sample; bubbles clear valid but keep the data
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s2_valid <= 1'b0;
         o_data   <= '0;
         o_ovf    <= 1'b0;
      end else if (load2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            o_data <= sat_data;
            o_ovf  <= sat_ovf;
         end
      end
   end

   // Sticky overflow: a saturating load into stage 2 wins over a clear
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_ovf_sticky <= 1'b0;
      end else if (load2 && s1_valid && sat_ovf) begin
         o_ovf_sticky <= 1'b1;
      end else if (i_ovf_clr) begin
         o_ovf_sticky <= 1'b0;
      end
   end

   assign o_valid = s2_valid;

endmodule

// File: tb/tb_signed_round_sat.sv
// tb_signed_round_sat
// Directed self-checking bench for signed_round_sat (IWID=17, OWID=12, D=5).
// Expected tie results follow SIGNED_ROUND_SAT_CONVERGENT_EN when defined.

module tb_signed_round_sat;

   localparam int IWID = 17;
   localparam int OWID = 12;

   logic            i_clk;
   logic            i_reset;
   logic            i_valid;
   logic            o_ready;
   logic [IWID-1:0] i_data;
   logic            o_valid;
   logic            i_ready;
   logic [OWID-1:0] o_data;
   logic            o_ovf;
   logic            i_ovf_clr;
   logic            o_ovf_sticky;

   int check_count = 0;
   int error_count = 0;

   signed_round_sat #(.IWID(IWID), .OWID(OWID)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_data       (i_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_ovf        (o_ovf),
      .i_ovf_clr    (i_ovf_clr),
      .o_ovf_sticky (o_ovf_sticky)
   );

   // Free-running clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      check_count++;
      if (observed != expected) begin
         error_count++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic stepCycle();
      @(posedge i_clk);
      #1;
   endtask

   // Push one sample through an empty pipeline and check it two edges later
   task automatic applyStimulus(input string tag, input int x, input int exp_data, input int exp_ovf);
      i_valid = 1'b1;
      i_data  = x[IWID-1:0];
      i_ready = 1'b1;
      stepCycle();
      i_valid = 1'b0;
      stepCycle();
      checkOutput({tag, "_valid"}, int'(o_valid), 1);
      checkOutput({tag, "_data"}, int'($signed(o_data)), exp_data);
      checkOutput({tag, "_ovf"}, int'(o_ovf), exp_ovf);
   endtask

   // Main directed sequence
   initial begin
      int sent;
      int recv;
      int occ;
      int cycles;
      int first_cycle;
      int out_count;
      int order_bad;
      logic prev_stall;
      logic [OWID-1:0] prev_data;

      i_reset   = 1'b1;
      i_valid   = 1'b0;
      i_data    = '0;
      i_ready   = 1'b1;
      i_ovf_clr = 1'b0;
      stepCycle();
      stepCycle();
      i_reset = 1'b0;

      checkOutput("rst_valid", int'(o_valid), 0);
      checkOutput("rst_data", int'($signed(o_data)), 0);
      checkOutput("rst_ovf", int'(o_ovf), 0);
      checkOutput("rst_sticky", int'(o_ovf_sticky), 0);
      checkOutput("rst_ready", int'(o_ready), 1);

      // Rounding ties
`ifdef SIGNED_ROUND_SAT_CONVERGENT_EN
      applyStimulus("tie_p16", 16, 0, 0);
      applyStimulus("tie_p48", 48, 2, 0);
      applyStimulus("tie_m16", -16, 0, 0);
      applyStimulus("tie_m48", -48, -2, 0);
`else
      applyStimulus("tie_p16", 16, 1, 0);
      applyStimulus("tie_p48", 48, 2, 0);
      applyStimulus("tie_m16", -16, 0, 0);
      applyStimulus("tie_m48", -48, -1, 0);
`endif
      checkOutput("tie_sticky", int'(o_ovf_sticky), 0);

      // Saturation boundaries
      applyStimulus("sat_max", 65535, 2047, 1);
      checkOutput("sat_sticky_set", int'(o_ovf_sticky), 1);
      applyStimulus("sat_edge", 65519, 2047, 0);
      applyStimulus("sat_min", -65536, -2048, 0);
      applyStimulus("sat_tie", 65520, 2047, 1);

      // Sticky: in-range data keeps it, a clear pulse drops it
      applyStimulus("stk_inrange", 100, 3, 0);
      checkOutput("stk_hold", int'(o_ovf_sticky), 1);
      i_ovf_clr = 1'b1;
      stepCycle();
      i_ovf_clr = 1'b0;
      checkOutput("stk_clear", int'(o_ovf_sticky), 0);

      // Clear in the same cycle as a saturating load into stage 2
      i_valid = 1'b1;
      i_data  = 17'(65535);
      stepCycle();
      i_valid   = 1'b0;
      i_ovf_clr = 1'b1;
      stepCycle();
      i_ovf_clr = 1'b0;
      checkOutput("stk_set_wins", int'(o_ovf_sticky), 1);
      checkOutput("stk_set_ovf", int'(o_ovf), 1);

      // Fill both stages under stall, then reset mid-stream
      i_ready = 1'b0;
      i_valid = 1'b1;
      i_data  = 17'(32);
      stepCycle();
      i_data = 17'(64);
      stepCycle();
      checkOutput("full_ready", int'(o_ready), 0);
      checkOutput("full_valid", int'(o_valid), 1);
      i_reset = 1'b1;
      stepCycle();
      i_reset = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      checkOutput("mrst_valid", int'(o_valid), 0);
      checkOutput("mrst_data", int'($signed(o_data)), 0);
      checkOutput("mrst_sticky", int'(o_ovf_sticky), 0);
      checkOutput("mrst_ready", int'(o_ready), 1);
      i_valid = 1'b1;
      i_data  = 17'(96);
      stepCycle();
      i_valid = 1'b0;
      checkOutput("post_rst_lat1", int'(o_valid), 0);
      stepCycle();
      checkOutput("post_rst_lat2", int'(o_valid), 1);
      checkOutput("post_rst_data", int'($signed(o_data)), 3);
      stepCycle();
      stepCycle();

      // Back-pressure stream 0..31 scaled by 32 with random i_ready
      sent       = 0;
      recv       = 0;
      cycles     = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      while (recv < 32 && cycles < 600) begin
         @(posedge i_clk);
         #1;
         i_ready = 1'($urandom_range(0, 1));
         i_valid = (sent < 32);
         i_data  = 17'(sent * 32);
         @(negedge i_clk);
         occ = sent - recv;
         if (prev_stall) begin
            checkOutput("bp_stall_valid", int'(o_valid), 1);
            checkOutput("bp_stall_data", int'(o_data), int'(prev_data));
         end
         checkOutput("bp_ready", int'(o_ready), (occ == 2 && !i_ready) ? 0 : 1);
         if (o_valid && i_ready) begin
            checkOutput("bp_data", int'($signed(o_data)), recv);
            recv++;
         end
         if (i_valid && o_ready) begin
            sent++;
         end
         prev_stall = o_valid && !i_ready;
         prev_data  = o_data;
         cycles++;
      end
      checkOutput("bp_count", recv, 32);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      stepCycle();
      stepCycle();

      // Throughput: 100 back-to-back samples
      first_cycle = -1;
      out_count   = 0;
      order_bad   = 0;
      for (int c = 0; c < 104; c++) begin
         @(posedge i_clk);
         #1;
         i_ready = 1'b1;
         i_valid = (c < 100);
         i_data  = 17'(c * 32);
         @(negedge i_clk);
         if (o_valid && i_ready) begin
            if (first_cycle < 0) first_cycle = c;
            if (int'($signed(o_data)) != out_count) order_bad++;
            out_count++;
         end
      end
      i_valid = 1'b0;
      checkOutput("tp_count", out_count, 100);
      checkOutput("tp_first", first_cycle, 2);
      checkOutput("tp_order", order_bad, 0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed %0d expected %0d", 1, 0);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
